// File: rtl/vram_write_scheduler_pkg.sv
// Shared definitions for the VRAM write path: state encoding, address split
// and the blank glyph, also used by the display controller.
package vram_write_scheduler_pkg;

  localparam int ROW_W  = 5;
  localparam int COL_W  = 6;
  localparam int ADDR_W = ROW_W + COL_W;
  localparam int DATA_W = 6;
  localparam int CHAR_W = ADDR_W + DATA_W;

  localparam logic [DATA_W-1:0] BLANK_GLYPH = 6'd32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LINE_CLR = 2'd1,
    ST_SCR_CLR  = 2'd2
  } state_e;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/vram_write_scheduler_char_fifo.sv
// Character FIFO: {addr, data} entries, full/empty by occupancy count,
// synchronous flush used by the screen clear.
module char_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic             clk25,
  input  logic             rst_n,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] pop_data,
  input  logic             flush
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign push_ready = (count_q != CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign push_ok    = push_valid && push_ready;
  assign pop_ok     = pop && !empty;
  assign pop_data   = mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, so resetting the array would only cost logic.
  always_ff @(posedge clk25) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/vram_write_scheduler.sv
// Arbitrates character writes, single-row clears and full-screen clears onto
// one registered VRAM write port.
module vram_write_scheduler
  import vram_write_scheduler_pkg::*;
#(
  parameter int                COLS       = 40,
  parameter int                ROWS       = 24,
  parameter logic [DATA_W-1:0] BLANK      = BLANK_GLYPH,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk25,
  input  logic              rst_n,
  input  logic              char_valid,
  output logic              char_ready,
  input  logic [ADDR_W-1:0] char_addr,
  input  logic [DATA_W-1:0] char_data,
  input  logic              line_clr_req,
  input  logic [ROW_W-1:0]  line_clr_row,
  input  logic              scr_clr_req,
  output logic              vram_w_en,
  output logic [ADDR_W-1:0] vram_w_addr,
  output logic [DATA_W-1:0] vram_din,
  output logic              busy
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d, pend_row_q, pend_row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              pend_valid_q, pend_valid_d;
  logic              vram_w_en_q, vram_w_en_d;
  logic [ADDR_W-1:0] vram_w_addr_q, vram_w_addr_d;
  logic [DATA_W-1:0] vram_din_q, vram_din_d;
  logic              clr_wr_q, clr_wr_d;
  logic              fifo_pop, fifo_flush, fifo_empty;
  logic [CHAR_W-1:0] fifo_rdata;

  char_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CHAR_W)) u_char_fifo (
    .clk25      (clk25),
    .rst_n      (rst_n),
    .push_valid (char_valid),
    .push_ready (char_ready),
    .push_data  ({char_addr, char_data}),
    .pop        (fifo_pop),
    .empty      (fifo_empty),
    .pop_data   (fifo_rdata),
    .flush      (fifo_flush)
  );

  assign vram_w_en   = vram_w_en_q;
  assign vram_w_addr = vram_w_addr_q;
  assign vram_din    = vram_din_q;
  // clr_wr_q keeps busy high while the final clear write is still on the port.
  assign busy = (state_q != ST_IDLE) || pend_valid_q || clr_wr_q;

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    pend_valid_d  = pend_valid_q;
    pend_row_d    = pend_row_q;
    vram_w_en_d   = 1'b0;
    vram_w_addr_d = vram_w_addr_q;
    vram_din_d    = vram_din_q;
    clr_wr_d      = 1'b0;
    fifo_pop      = 1'b0;
    fifo_flush    = 1'b0;

    if (scr_clr_req) begin
      // Screen clear wins outright: (re)start the sweep, drop everything else.
      state_d      = ST_SCR_CLR;
      row_d        = '0;
      col_d        = '0;
      pend_valid_d = 1'b0;
      fifo_flush   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (line_clr_req) begin
            state_d = ST_LINE_CLR;
            row_d   = line_clr_row;
            col_d   = '0;
          end else if (!fifo_empty) begin
            fifo_pop      = 1'b1;
            vram_w_en_d   = 1'b1;
            vram_w_addr_d = fifo_rdata[CHAR_W-1:DATA_W];
            vram_din_d    = fifo_rdata[DATA_W-1:0];
          end
        end
        ST_LINE_CLR: begin
          vram_w_en_d   = 1'b1;
          vram_w_addr_d = pack_addr(row_q, col_q);
          vram_din_d    = BLANK;
          clr_wr_d      = 1'b1;
          if (col_q == COL_LAST) begin
            col_d        = '0;
            pend_valid_d = 1'b0;
            if (line_clr_req)      row_d = line_clr_row;
            else if (pend_valid_q) row_d = pend_row_q;
            else                   state_d = ST_IDLE;
          end else begin
            col_d = col_q + COL_W'(1);
            if (line_clr_req) begin
              pend_valid_d = 1'b1;
              pend_row_d   = line_clr_row;
            end
          end
        end
        ST_SCR_CLR: begin
          vram_w_en_d   = 1'b1;
          vram_w_addr_d = pack_addr(row_q, col_q);
          vram_din_d    = BLANK;
          clr_wr_d      = 1'b1;
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = ST_IDLE;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      row_q         <= '0;
      col_q         <= '0;
      pend_valid_q  <= 1'b0;
      pend_row_q    <= '0;
      vram_w_en_q   <= 1'b0;
      vram_w_addr_q <= '0;
      vram_din_q    <= '0;
      clr_wr_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      pend_valid_q  <= pend_valid_d;
      pend_row_q    <= pend_row_d;
      vram_w_en_q   <= vram_w_en_d;
      vram_w_addr_q <= vram_w_addr_d;
      vram_din_q    <= vram_din_d;
      clr_wr_q      <= clr_wr_d;
    end
  end

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Directed bench for vram_write_scheduler: character path, FIFO full,
// screen clear, chained line clears, abort with flush, reset mid-clear.
module tb_vram_write_scheduler;

  localparam int         COLS  = 40;
  localparam int         ROWS  = 24;
  localparam logic [5:0] BLANK = 6'd32;

  logic        clk25, rst_n;
  logic        char_valid, char_ready;
  logic [10:0] char_addr;
  logic [5:0]  char_data;
  logic        line_clr_req;
  logic [4:0]  line_clr_row;
  logic        scr_clr_req;
  logic        vram_w_en;
  logic [10:0] vram_w_addr;
  logic [5:0]  vram_din;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  vram_write_scheduler dut (
    .clk25        (clk25),
    .rst_n        (rst_n),
    .char_valid   (char_valid),
    .char_ready   (char_ready),
    .char_addr    (char_addr),
    .char_data    (char_data),
    .line_clr_req (line_clr_req),
    .line_clr_row (line_clr_row),
    .scr_clr_req  (scr_clr_req),
    .vram_w_en    (vram_w_en),
    .vram_w_addr  (vram_w_addr),
    .vram_din     (vram_din),
    .busy         (busy)
  );

  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // n consecutive BLANK writes to {row, col0+i}, busy high on each.
  task automatic expect_run(input string tag, input logic [4:0] row, input int col0, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk25);
      if (!(vram_w_en === 1'b1 && vram_w_addr === {row, 6'(col0 + i)} &&
            vram_din === BLANK && busy === 1'b1)) bad++;
    end
    check(tag, bad, 0);
  endtask

  // Full-screen sweep, optionally pushing n_push characters from its start.
  task automatic sweep_scr(input string tag, input int n_push);
    int          bad    = 0;
    int          pushed = 0;
    logic        ready_s;
    logic [10:0] exp_a;
    for (int i = 0; i < ROWS * COLS; i++) begin
      if (pushed < n_push) begin
        char_valid = 1'b1;
        char_addr  = 11'h100 + 11'(pushed);
        char_data  = 6'(pushed + 1);
      end
      ready_s = char_ready;
      if (n_push > 0 && i == 4) check({tag, "_ready_full"}, char_ready, 0);
      @(negedge clk25);
      if (char_valid && ready_s) pushed++;
      exp_a = {5'(i / COLS), 6'(i % COLS)};
      if (!(vram_w_en === 1'b1 && vram_w_addr === exp_a &&
            vram_din === BLANK && busy === 1'b1)) bad++;
    end
    check({tag, "_sweep"}, bad, 0);
    if (n_push > 0) check({tag, "_accepted"}, pushed, 4);
  endtask

  task automatic expect_char(input string tag, input logic [10:0] a, input logic [5:0] d);
    @(negedge clk25);
    check(tag, {vram_w_en, vram_w_addr, vram_din}, {1'b1, a, d});
  endtask

  initial begin
    int writes;
    rst_n = 1'b1; char_valid = 1'b0; char_addr = '0; char_data = '0;
    line_clr_req = 1'b0; line_clr_row = '0; scr_clr_req = 1'b0;
    #5 rst_n = 1'b0;
    #1;
    check("rst_w_en", vram_w_en, 0);
    check("rst_addr", vram_w_addr, 0);
    check("rst_din", vram_din, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", char_ready, 1);
    @(negedge clk25); @(negedge clk25);
    rst_n = 1'b1;
    @(negedge clk25);

    // Single character: accepted at edge N, on the port after edge N+1.
    char_valid = 1'b1; char_addr = 11'h041; char_data = 6'h05;
    @(negedge clk25);
    char_valid = 1'b0;
    check("char_not_yet", vram_w_en, 0);
    expect_char("char_write", 11'h041, 6'h05);
    @(negedge clk25);
    check("char_once", vram_w_en, 0);

    // Screen clear with five pushes: fourth fills the FIFO, fifth waits.
    scr_clr_req = 1'b1;
    @(negedge clk25);
    scr_clr_req = 1'b0;
    check("scr_start_busy", busy, 1);
    sweep_scr("scr1", 5);
    expect_char("drain_c0", 11'h100, 6'd1);
    check("ready_after_pop", char_ready, 1);
    @(negedge clk25);
    char_valid = 1'b0;
    check("drain_c1", {vram_w_en, vram_w_addr, vram_din}, {1'b1, 11'h101, 6'd2});
    expect_char("drain_c2", 11'h102, 6'd3);
    expect_char("drain_c3", 11'h103, 6'd4);
    expect_char("drain_c4", 11'h104, 6'd5);
    @(negedge clk25);
    check("drain_done_en", vram_w_en, 0);
    check("drain_done_busy", busy, 0);

    // Row 3 clear; row 7 then row 9 requested mid-clear, 9 overwrites 7.
    line_clr_req = 1'b1; line_clr_row = 5'd3;
    @(negedge clk25);
    line_clr_req = 1'b0;
    check("l3_start", {busy, vram_w_en}, 2'b10);
    expect_run("l3_a", 5'd3, 0, 5);
    line_clr_req = 1'b1; line_clr_row = 5'd7;
    expect_run("l3_b", 5'd3, 5, 1);
    line_clr_req = 1'b0;
    expect_run("l3_c", 5'd3, 6, 4);
    line_clr_req = 1'b1; line_clr_row = 5'd9;
    expect_run("l3_d", 5'd3, 10, 1);
    line_clr_req = 1'b0;
    expect_run("l3_e", 5'd3, 11, 29);
    expect_run("l9", 5'd9, 0, 40);
    @(negedge clk25);
    check("l9_done", {busy, vram_w_en}, 2'b00);

    // Abort a row-5 clear at column 20 with chars queued; FIFO gets flushed.
    line_clr_req = 1'b1; line_clr_row = 5'd5;
    @(negedge clk25);
    line_clr_req = 1'b0;
    char_valid = 1'b1; char_addr = 11'h2AA; char_data = 6'h15;
    expect_run("l5_a", 5'd5, 0, 2);
    char_valid = 1'b0;
    expect_run("l5_b", 5'd5, 2, 18);
    scr_clr_req = 1'b1;
    @(negedge clk25);
    scr_clr_req = 1'b0;
    check("abort_gap", vram_w_en, 0);
    sweep_scr("scr2", 0);
    @(negedge clk25);
    check("flushed_no_char", vram_w_en, 0);
    check("flushed_idle", busy, 0);

    // Reset in the middle of a screen clear.
    scr_clr_req = 1'b1;
    @(negedge clk25);
    scr_clr_req = 1'b0;
    repeat (100) @(negedge clk25);
    check("pre_rst_writing", vram_w_en, 1);
    #5 rst_n = 1'b0;
    #1;
    check("midrst_w_en", vram_w_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_addr", vram_w_addr, 0);
    check("midrst_ready", char_ready, 1);
    @(negedge clk25); @(negedge clk25);
    rst_n = 1'b1;
    writes = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk25);
      if (vram_w_en !== 1'b0 || busy !== 1'b0) writes++;
    end
    check("no_resume", writes, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
